// File: rtl/dtc_rr_scheduler.sv
// Round-robin front end that time-shares one combinational decision-tree classifier among NREQ requesters.
// Optional per-requester grant statistics are built when DTC_SCHED_STATS_EN is defined.
module dtc_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 7,
   parameter int OUT_W = 10,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*IN_W-1:0]   req_inp,
   output logic [NREQ-1:0]        req_ready,
   output logic [IN_W-1:0]        tree_inp,
   input  logic [OUT_W-1:0]       tree_outp,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [OUT_W-1:0]       rsp_outp,
   input  logic                   rsp_ready,
   output logic                   busy,
   input  logic [ID_W-1:0]        stat_sel,
   input  logic                   stat_clr,
   output logic [15:0]            stat_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [ID_W-1:0]   grant_idx_s;
   logic [ID_W-1:0]   cand_s;
   logic              grant_found_s;
   logic              grant_s;

   // Rotating priority search starting one past the last granted requester.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {ID_W{1'b0}};
      cand_s        = {ID_W{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = ID_W'((int'(rr_ptr_r) + k) % NREQ);
         if (!grant_found_s && req_valid[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign grant_s = rst_n && (state_r == ST_IDLE) && grant_found_s;

   // One-hot accept pulse, only ever raised in IDLE outside reset.
   always_comb begin
      req_ready = {NREQ{1'b0}};
      if (grant_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   // Next-state logic for the IDLE -> EVAL -> HOLD cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) state_nxt_s = ST_EVAL;
            else         state_nxt_s = ST_IDLE;
         end
         ST_EVAL: state_nxt_s = ST_HOLD;
         ST_HOLD: begin
            if (rsp_valid && rsp_ready) state_nxt_s = ST_IDLE;
            else                        state_nxt_s = ST_HOLD;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, capture of the granted feature and the tree result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         tree_inp  <= {IN_W{1'b0}};
         rsp_valid <= 1'b0;
         rsp_id    <= {ID_W{1'b0}};
         rsp_outp  <= {OUT_W{1'b0}};
         rr_ptr_r  <= ID_W'(NREQ - 1);
      end else begin
         state_r <= state_nxt_s;
         if (grant_s) begin
            tree_inp <= req_inp[int'(grant_idx_s) * IN_W +: IN_W];
            rsp_id   <= grant_idx_s;
            rr_ptr_r <= grant_idx_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
         // EVAL gives the combinational tree one full cycle to settle before sampling.
         if (state_r == ST_EVAL) begin
            rsp_outp  <= tree_outp;
            rsp_valid <= 1'b1;
         end else if ((state_r == ST_HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end else begin
            rsp_valid <= rsp_valid;
         end
      end
   end

   assign busy = (state_r != ST_IDLE);

`ifdef DTC_SCHED_STATS_EN
   logic [15:0] cnt_r [NREQ];

   // Saturating grant counters; a clear request overrides a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_r[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && (cnt_r[i] != 16'hFFFF)) begin
               cnt_r[i] <= cnt_r[i] + 16'h0001;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // Readout mux; selectors beyond the requester count read zero.
   always_comb begin
      stat_cnt = 16'h0000;
      if (int'(stat_sel) < NREQ) begin
         stat_cnt = cnt_r[stat_sel];
      end else begin
         stat_cnt = 16'h0000;
      end
   end
`else
   logic unused_stat_s;
   assign unused_stat_s = ^{stat_sel, stat_clr};
   assign stat_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_dtc_rr_scheduler.sv
// Directed bench for dtc_rr_scheduler with a pass-through tree stub; inputs change and outputs are sampled on the falling edge.
module tb_dtc_rr_scheduler;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [27:0] req_inp;
   logic [3:0]  req_ready;
   logic [6:0]  tree_inp;
   logic [9:0]  tree_outp;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [9:0]  rsp_outp;
   logic        rsp_ready;
   logic        busy;
   logic [1:0]  stat_sel;
   logic        stat_clr;
   logic [15:0] stat_cnt;

   int checks = 0;
   int errors = 0;

   dtc_rr_scheduler #(.NREQ(4), .IN_W(7), .OUT_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_inp(req_inp),
      .req_ready(req_ready), .tree_inp(tree_inp), .tree_outp(tree_outp),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_outp(rsp_outp),
      .rsp_ready(rsp_ready), .busy(busy), .stat_sel(stat_sel),
      .stat_clr(stat_clr), .stat_cnt(stat_cnt)
   );

   assign tree_outp = {3'b000, tree_inp};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One full transaction from IDLE with rsp_ready held high.
   task automatic run_txn(input logic [3:0] v, input logic [27:0] inp, input logic [3:0] er,
                          input logic [1:0] eid, input logic [9:0] eo, input string nm);
      req_valid = v;
      req_inp   = inp;
      rsp_ready = 1'b1;
      #1;
      check(32'(req_ready), 32'(er), {nm, ".ready"});
      @(negedge clk);
      check(32'(busy), 32'd1, {nm, ".busy"});
      check(32'(req_ready), 32'd0, {nm, ".ready_eval"});
      check(32'(tree_inp), 32'(eo[6:0]), {nm, ".tree_inp"});
      check(32'(rsp_valid), 32'd0, {nm, ".valid_eval"});
      @(negedge clk);
      check(32'(rsp_valid), 32'd1, {nm, ".valid"});
      check(32'(rsp_id), 32'(eid), {nm, ".id"});
      check(32'(rsp_outp), 32'(eo), {nm, ".outp"});
      req_valid = 4'b0000;
      @(negedge clk);
      check(32'(rsp_valid), 32'd0, {nm, ".valid_done"});
      check(32'(busy), 32'd0, {nm, ".idle"});
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [27:0] inp;
      logic [3:0]  rdy;
      logic [1:0]  id;
      logic [9:0]  outp;
   } vec_t;

   vec_t vecs[12];
   int   exp_order[6];
   int   gcount;
   int   last_c;

   initial begin
      vecs[0]  = '{4'b0001, {7'h00, 7'h00, 7'h00, 7'h2A}, 4'b0001, 2'd0, 10'h02A};
      vecs[1]  = '{4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0010, 2'd1, 10'h022};
      vecs[2]  = '{4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0100, 2'd2, 10'h033};
      vecs[3]  = '{4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b1000, 2'd3, 10'h044};
      vecs[4]  = '{4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0001, 2'd0, 10'h011};
      vecs[5]  = '{4'b0100, {7'h00, 7'h7F, 7'h00, 7'h00}, 4'b0100, 2'd2, 10'h07F};
      vecs[6]  = '{4'b1010, {7'h05, 7'h00, 7'h60, 7'h00}, 4'b1000, 2'd3, 10'h005};
      vecs[7]  = '{4'b1010, {7'h05, 7'h00, 7'h60, 7'h00}, 4'b0010, 2'd1, 10'h060};
      vecs[8]  = '{4'b0011, {7'h00, 7'h00, 7'h55, 7'h00}, 4'b0001, 2'd0, 10'h000};
      vecs[9]  = '{4'b1000, {7'h7F, 7'h00, 7'h00, 7'h00}, 4'b1000, 2'd3, 10'h07F};
      vecs[10] = '{4'b0110, {7'h00, 7'h01, 7'h02, 7'h00}, 4'b0010, 2'd1, 10'h002};
      vecs[11] = '{4'b0110, {7'h00, 7'h01, 7'h02, 7'h00}, 4'b0100, 2'd2, 10'h001};
      exp_order = '{0, 1, 2, 3, 0, 1};

      rst_n = 1'b0; req_valid = 4'b1111; req_inp = {7'h44, 7'h33, 7'h22, 7'h11};
      rsp_ready = 1'b1; stat_sel = 2'd0; stat_clr = 1'b0;

      // Reset state, with requests pending while reset is held
      @(negedge clk);
      check(32'(req_ready), 32'd0, "rst.ready");
      check(32'(busy), 32'd0, "rst.busy");
      check(32'(rsp_valid), 32'd0, "rst.valid");
      check(32'(tree_inp), 32'd0, "rst.tree_inp");
      check(32'(rsp_outp), 32'd0, "rst.outp");
      check(32'(rsp_id), 32'd0, "rst.id");
      check(32'(stat_cnt), 32'd0, "rst.stat");
      rst_n = 1'b1; req_valid = 4'b0000;
      @(negedge clk);
      check(32'(busy), 32'd0, "idle_no_req.busy");

      // Table of transactions walking the round-robin pointer
      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].v, vecs[i].inp, vecs[i].rdy, vecs[i].id, vecs[i].outp, $sformatf("vec%0d", i));
      end

      // Continuous requests from all four: order 0,1,2,3,0,1 spaced 3 cycles
      do_reset();
      req_valid = 4'b1111; req_inp = {7'h44, 7'h33, 7'h22, 7'h11}; rsp_ready = 1'b1;
      gcount = 0; last_c = -1;
      for (int c = 0; c < 40 && gcount < 6; c++) begin
         #1;
         if (req_ready != 4'b0000) begin
            check(32'(req_ready), 32'd1 << exp_order[gcount], $sformatf("rr.grant%0d", gcount));
            if (gcount > 0) check(32'(c - last_c), 32'd3, $sformatf("rr.spacing%0d", gcount));
            last_c = c;
            gcount++;
         end
         @(negedge clk);
      end
      check(32'(gcount), 32'd6, "rr.grant_count");
      req_valid = 4'b0000;
      @(negedge clk); @(negedge clk); @(negedge clk);

      // Consumer stalls five cycles in HOLD
      do_reset();
      req_valid = 4'b0001; req_inp = {7'h00, 7'h00, 7'h00, 7'h2A}; rsp_ready = 1'b0;
      #1; check(32'(req_ready), 32'd1, "stall.ready");
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         check(32'(rsp_valid), 32'd1, $sformatf("stall.valid%0d", k));
         check(32'(rsp_outp), 32'h02A, $sformatf("stall.outp%0d", k));
         check(32'(rsp_id), 32'd0, $sformatf("stall.id%0d", k));
         check(32'(req_ready), 32'd0, $sformatf("stall.ready%0d", k));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1; check(32'(rsp_valid), 32'd1, "stall.release_valid");
      @(negedge clk);
      check(32'(rsp_valid), 32'd0, "stall.done_valid");
      check(32'(req_ready), 32'd1, "stall.regrant");
      req_valid = 4'b0000;
      @(negedge clk);

      // Wrap from pointer 3 to a lone requester 2, then 3 before 1
      do_reset();
      run_txn(4'b0100, {7'h00, 7'h19, 7'h00, 7'h00}, 4'b0100, 2'd2, 10'h019, "wrap.r2");
      run_txn(4'b1010, {7'h3C, 7'h00, 7'h4B, 7'h00}, 4'b1000, 2'd3, 10'h03C, "wrap.r3");
      run_txn(4'b1010, {7'h3C, 7'h00, 7'h4B, 7'h00}, 4'b0010, 2'd1, 10'h04B, "wrap.r1");

      // Reset while the tree is evaluating discards the result
      run_txn(4'b1000, {7'h70, 7'h00, 7'h00, 7'h00}, 4'b1000, 2'd3, 10'h070, "pre.r3");
      req_valid = 4'b0001; req_inp = {7'h00, 7'h00, 7'h00, 7'h2A}; rsp_ready = 1'b1;
      @(negedge clk);
      check(32'(busy), 32'd1, "mid.busy_eval");
      rst_n = 1'b0;
      @(negedge clk);
      check(32'(busy), 32'd0, "mid.busy");
      check(32'(rsp_valid), 32'd0, "mid.valid");
      check(32'(tree_inp), 32'd0, "mid.tree_inp");
      check(32'(rsp_id), 32'd0, "mid.id");
      check(32'(rsp_outp), 32'd0, "mid.outp");
      check(32'(req_ready), 32'd0, "mid.ready");
      rst_n = 1'b1;
      run_txn(4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0001, 2'd0, 10'h011, "mid.first");

`ifdef DTC_SCHED_STATS_EN
      do_reset();
      for (int n = 0; n < 10; n++) begin
         run_txn(4'b0010, {7'h00, 7'h00, 7'h12, 7'h00}, 4'b0010, 2'd1, 10'h012, $sformatf("stat.g%0d", n));
      end
      stat_sel = 2'd1; #1; check(32'(stat_cnt), 32'd10, "stat.cnt10");
      stat_sel = 2'd0; #1; check(32'(stat_cnt), 32'd0, "stat.cnt_r0");
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0; stat_sel = 2'd1;
      #1; check(32'(stat_cnt), 32'd0, "stat.clr");
      @(negedge clk);
      dut.cnt_r[1] <= 16'hFFFE;
      #1;
      run_txn(4'b0010, {7'h00, 7'h00, 7'h12, 7'h00}, 4'b0010, 2'd1, 10'h012, "sat.g0");
      check(32'(stat_cnt), 32'h0000FFFF, "sat.cnt1");
      run_txn(4'b0010, {7'h00, 7'h00, 7'h12, 7'h00}, 4'b0010, 2'd1, 10'h012, "sat.g1");
      run_txn(4'b0010, {7'h00, 7'h00, 7'h12, 7'h00}, 4'b0010, 2'd1, 10'h012, "sat.g2");
      check(32'(stat_cnt), 32'h0000FFFF, "sat.cnt3");
`else
      stat_sel = 2'd1; stat_clr = 1'b0;
      run_txn(4'b0010, {7'h00, 7'h00, 7'h12, 7'h00}, 4'b0010, 2'd1, 10'h012, "nostat.g");
      #1; check(32'(stat_cnt), 32'd0, "nostat.cnt");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
